nvdla_rst_stage_seq: RTL and testbench

//  Reset release sequencer downstream of the NV_BLKBOX tie-off sources. Synchronises the

---
 rtl/nvdla_rst_stage_seq.sv | 128 ++++++++++++
 tb/tb_nvdla_rst_stage_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/nvdla_rst_stage_seq.sv
// Reset release sequencer: synchronises the core reset, then releases NUM_STAGES
// sub-partition resets in order at fixed spacing, with soft re-sequence and test bypass.
//
// state   | meaning
// RESET   | waiting for the synchronised core reset to deassert
// RELEASE | releasing stages one by one every STAGE_GAP edges
// DONE    | all stages released, soft-reset request honoured here only
// HOLD    | soft reset in progress, all stages held for STAGE_GAP edges
module nvdla_rst_stage_seq #(
  parameter int SYNC_DEPTH = 3,
  parameter int NUM_STAGES = 4,
  parameter int STAGE_GAP  = 8
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic                  tie_lo,
  input  logic                  sw_rst_req,
  input  logic                  test_mode,
  input  logic                  test_rstn,
  output logic [NUM_STAGES-1:0] stage_rstn,
  output logic                  seq_done,
  output logic                  busy
);

  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int SW = $clog2(NUM_STAGES + 1);
  localparam logic [GW-1:0]         GAP_ONE  = GW'(1);
  localparam logic [GW-1:0]         GAP_MAX  = GW'(STAGE_GAP);
  localparam logic [SW-1:0]         STG_LAST = SW'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] STG_ONE  = NUM_STAGES'(1);

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_RELEASE = 2'd1,
    S_DONE    = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_DEPTH-1:0]   chain_q, chain_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [SW-1:0]           stg_q, stg_d;
  logic [NUM_STAGES-1:0]   stage_q, stage_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    synced_rstn;
  logic                    rel_ok;

  assign chain_d     = {chain_q[SYNC_DEPTH-2:0], ~tie_lo};
  assign synced_rstn = chain_q[SYNC_DEPTH-1];
  // Leave RESET on the edge that sets the last sync flop, so stage 0 lands at
  // SYNC_DEPTH + STAGE_GAP edges after release.
  assign rel_ok      = chain_d[SYNC_DEPTH-1] | synced_rstn;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q <= S_RESET;
      chain_q <= '0;
      gap_q   <= '0;
      stg_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chain_q <= chain_d;
      gap_q   <= gap_d;
      stg_q   <= stg_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    stg_d   = stg_q;
    stage_d = stage_q;
    done_d  = done_q;
    case (state_q)
      S_RESET: begin
        if (rel_ok) begin
          state_d = S_RELEASE;
          gap_d   = GAP_ONE;
        end
      end
      S_RELEASE: begin
        if (gap_q == GAP_MAX) begin
          stage_d = (stage_q << 1) | STG_ONE;
          gap_d   = GAP_ONE;
          stg_d   = stg_q + SW'(1);
          if (stg_q == STG_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end
      S_DONE: begin
        if (sw_rst_req) begin
          state_d = S_HOLD;
          stage_d = '0;
          done_d  = 1'b0;
          gap_d   = GAP_ONE;
          stg_d   = '0;
        end
      end
      S_HOLD: begin
        if (gap_q == GAP_MAX) begin
          state_d = S_RELEASE;
          gap_d   = GAP_ONE;
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end
      default: state_d = S_RESET;
    endcase
    busy_d = (state_d == S_HOLD) || (state_d == S_RELEASE) ||
             ((state_d == S_RESET) && (|chain_d));
  end

  assign stage_rstn = test_mode ? {NUM_STAGES{test_rstn}} : stage_q;
  assign seq_done   = test_mode ? test_rstn : done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_nvdla_rst_stage_seq.sv
// Self-checking bench for nvdla_rst_stage_seq: POR table, mid-sequence reset,
// soft reset, ignored requests, test bypass and stuck tie_lo.
module tb_nvdla_rst_stage_seq;

  localparam int GAP = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tie_lo = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       test_mode = 1'b0;
  logic       test_rstn = 1'b0;
  logic [3:0] stage_rstn;
  logic       seq_done;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         edge_no;
    logic [3:0] stg;
    logic       done;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [3:0] stg;
    logic       done;
    logic       busy;
  } exp_t;

  vec_t tbl[10];
  exp_t sb_q[$];

  nvdla_rst_stage_seq #(.SYNC_DEPTH(3), .NUM_STAGES(4), .STAGE_GAP(GAP)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .tie_lo          (tie_lo),
    .sw_rst_req      (sw_rst_req),
    .test_mode       (test_mode),
    .test_rstn       (test_rstn),
    .stage_rstn      (stage_rstn),
    .seq_done        (seq_done),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int n, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%h exp=%h", nm, n, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int n, input logic [3:0] s, input logic d, input logic b);
    chk({nm, "_stage"}, n, stage_rstn, s);
    chk({nm, "_done"}, n, {3'b000, seq_done}, {3'b000, d});
    chk({nm, "_busy"}, n, {3'b000, busy}, {3'b000, b});
  endtask

  function automatic logic [3:0] exp_mask(input int n, input int off);
    logic [3:0] m = 4'h0;
    for (int k = 0; k < 4; k++)
      if (n >= off + (k + 1) * GAP) m[k] = 1'b1;
    return m;
  endfunction

  // Release reset so that the next rising edge is edge 1 of the timeline.
  task automatic por(input string nm);
    rstn = 1'b0;
    #1;
    chk_all({nm, "_rst"}, 0, 4'h0, 1'b0, 1'b0);
    repeat (5) tick();
    chk_all({nm, "_rst_hold"}, 0, 4'h0, 1'b0, 1'b0);
    rstn = 1'b1;
  endtask

  task automatic run_seq(input string nm, input int off, input int n_from, input int n_to,
                         input int sw_a, input int sw_b);
    exp_t e, g;
    for (int n = n_from; n <= n_to; n++) begin
      sw_rst_req = (n == sw_a) || (n == sw_b);
      e.stg  = exp_mask(n, off);
      e.done = (e.stg == 4'hF);
      e.busy = !e.done;
      sb_q.push_back(e);
      tick();
      g = sb_q.pop_front();
      chk_all(nm, n, g.stg, g.done, g.busy);
    end
    sw_rst_req = 1'b0;
  endtask

  initial begin
    int idx;
    tbl[0] = '{2,  4'h0, 1'b0, 1'b1};
    tbl[1] = '{10, 4'h0, 1'b0, 1'b1};
    tbl[2] = '{11, 4'h1, 1'b0, 1'b1};
    tbl[3] = '{18, 4'h1, 1'b0, 1'b1};
    tbl[4] = '{19, 4'h3, 1'b0, 1'b1};
    tbl[5] = '{26, 4'h3, 1'b0, 1'b1};
    tbl[6] = '{27, 4'h7, 1'b0, 1'b1};
    tbl[7] = '{34, 4'h7, 1'b0, 1'b1};
    tbl[8] = '{35, 4'hF, 1'b1, 1'b0};
    tbl[9] = '{40, 4'hF, 1'b1, 1'b0};

    // Power-on timeline against the spot table
    @(posedge clk);
    #1;
    por("por");
    idx = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (idx < 10 && tbl[idx].edge_no == n) begin
        chk_all("por_tbl", n, tbl[idx].stg, tbl[idx].done, tbl[idx].busy);
        idx++;
      end
    end

    // Mid-sequence reset, then an identical timeline from the new release
    por("mid");
    run_seq("mid_pre", 3, 1, 20, -1, -1);
    rstn = 1'b0;
    #1;
    chk_all("mid_drop", 20, 4'h0, 1'b0, 1'b0);
    tick();
    tick();
    rstn = 1'b1;
    run_seq("mid_post", 3, 1, 36, -1, -1);

    // Single-cycle soft reset request in DONE
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    chk_all("soft_e0", 0, 4'h0, 1'b0, 1'b1);
    run_seq("soft", 8, 1, 41, -1, -1);

    // Requests during RELEASE are ignored
    por("ign");
    run_seq("ign", 3, 1, 40, 12, 30);

    // Test bypass during RELEASE, registered values return at edge 30
    por("tm");
    run_seq("tm_pre", 3, 1, 20, -1, -1);
    test_mode = 1'b1;
    test_rstn = 1'b0;
    #1;
    chk("tm_stage0", 20, stage_rstn, 4'h0);
    chk("tm_done0", 20, {3'b000, seq_done}, 4'h0);
    test_rstn = 1'b1;
    #1;
    chk("tm_stage1", 20, stage_rstn, 4'hF);
    chk("tm_done1", 20, {3'b000, seq_done}, 4'h1);
    tick();
    chk("tm_stage1_e21", 21, stage_rstn, 4'hF);
    test_rstn = 1'b0;
    #1;
    chk("tm_stage0b", 21, stage_rstn, 4'h0);
    repeat (9) tick();
    chk("tm_stage0_e30", 30, stage_rstn, 4'h0);
    test_mode = 1'b0;
    #1;
    chk_all("tm_exit", 30, 4'h7, 1'b0, 1'b1);
    run_seq("tm_post", 3, 31, 36, -1, -1);

    // Stuck tie_lo keeps everything in reset
    tie_lo = 1'b1;
    por("tie");
    for (int n = 1; n <= 1000; n++) begin
      tick();
      if (n % 50 == 0) chk_all("tie_stuck", n, 4'h0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
